// File: rtl/hdr_ingress_arbiter_if.sv
// hdr_ingress_arbiter_if: bundle between the ingress streams, the arbiter and the checker.
// master drives requests/enables and observes; slave (the arbiter) drives ready, byte and status.
interface hdr_ingress_arbiter_if #(
    parameter int N_PORTS = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
);
    logic [N_PORTS-1:0]   port_enable;
    logic [8*N_PORTS-1:0] req_data;
    logic [N_PORTS-1:0]   req_valid;
    logic [N_PORTS-1:0]   req_last;
    logic [N_PORTS-1:0]   req_ready;
    logic [7:0]           data;
    logic                 control;
    logic [N_PORTS-1:0]   grant;
    logic [ID_W-1:0]      grant_id;
    logic                 busy;
    logic                 underrun;
    logic [CNT_W-1:0]     frame_count;

    modport master (
        output port_enable, req_data, req_valid, req_last,
        input  req_ready, data, control, grant, grant_id,
        input  busy, underrun, frame_count
    );

    modport slave (
        input  port_enable, req_data, req_valid, req_last,
        output req_ready, data, control, grant, grant_id,
        output busy, underrun, frame_count
    );
endinterface

// File: rtl/hdr_ingress_arbiter.sv
// hdr_ingress_arbiter: frame-granular round-robin arbiter feeding one byte-wide header checker.
// Ports: clock; reset (async, active-high); bus (slave): port_enable, req_data/valid/last in,
//   req_ready, data/control, grant/grant_id, busy, underrun, frame_count out.
// Macro ARB_IFG_EN: when defined (and IFG_CYCLES>0) a GAP of IFG_CYCLES cycles follows each frame.
module hdr_ingress_arbiter #(
    parameter int N_PORTS    = 4,
    parameter int ID_W       = 2,
    parameter int CNT_W      = 16,
    parameter int IFG_CYCLES = 12
) (
    input  logic                 clock,
    input  logic                 reset,
    hdr_ingress_arbiter_if.slave bus
);

`ifdef ARB_IFG_EN
    localparam int GAP_LEN = IFG_CYCLES;
`else
    // Gap length is forced to zero when the feature is compiled out.
    localparam int GAP_LEN = 0 * IFG_CYCLES;
`endif
    localparam bit USE_GAP = (GAP_LEN > 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [7:0]         data_q, data_nx;
    logic               control_q, control_nx;
    logic [N_PORTS-1:0] grant_q, grant_nx;
    logic [ID_W-1:0]    gid_q, gid_nx;
    logic [ID_W-1:0]    rr_ptr, rr_nx;
    logic               underrun_q, underrun_nx;
    logic [CNT_W-1:0]   count_q, count_nx;

    logic [N_PORTS-1:0] eligible;
    logic [ID_W-1:0]    pick;
    logic               pick_ok;
    logic               xfer;
    logic               xfer_last;
    logic               gap_done;

    assign eligible  = bus.req_valid & bus.port_enable;
    // Only the owner's lines matter; everyone else is ignored while a frame runs.
    assign xfer      = (state == XFER) && bus.req_valid[gid_q];
    assign xfer_last = xfer && bus.req_last[gid_q];

    // First eligible port after rr_ptr, wrapping modulo N_PORTS.
    always_comb begin : rr_pick
        int idx;
        idx     = 0;
        pick    = rr_ptr;
        pick_ok = 1'b0;
        for (int k = 1; k <= N_PORTS; k++) begin
            idx = (int'(rr_ptr) + k) % N_PORTS;
            if (!pick_ok && eligible[idx]) begin
                pick_ok = 1'b1;
                pick    = ID_W'(idx);
            end
        end
    end

    generate
        if (USE_GAP) begin : g_gap
            localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
            logic [GW-1:0] gap_cnt;
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    gap_cnt <= '0;
                end else if (state == GAP) begin
                    gap_cnt <= gap_cnt + GW'(1);
                end else begin
                    gap_cnt <= '0;
                end
            end
            assign gap_done = (gap_cnt == GW'(GAP_LEN - 1));
        end else begin : g_no_gap
            assign gap_done = 1'b1;
        end
    endgenerate

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (pick_ok) state_nx = XFER;
            XFER: if (xfer_last) state_nx = USE_GAP ? GAP : IDLE;
            GAP:  if (gap_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        data_nx     = data_q;
        control_nx  = 1'b0;
        grant_nx    = grant_q;
        gid_nx      = gid_q;
        rr_nx       = rr_ptr;
        underrun_nx = 1'b0;
        count_nx    = count_q;
        unique case (state)
            IDLE: begin
                grant_nx = '0;
                if (pick_ok) begin
                    grant_nx[pick] = 1'b1;
                    gid_nx         = pick;
                end
            end
            XFER: begin
                if (xfer) begin
                    data_nx    = bus.req_data[8*gid_q +: 8];
                    control_nx = 1'b1;
                    if (xfer_last) begin
                        count_nx = count_q + CNT_W'(1);
                        rr_nx    = gid_q;
                        grant_nx = '0;
                    end
                end else begin
                    // Bubble: the checker sees an abort, the grant is kept.
                    underrun_nx = 1'b1;
                end
            end
            GAP: grant_nx = '0;
            default: grant_nx = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_q     <= '0;
            control_q  <= 1'b0;
            grant_q    <= '0;
            gid_q      <= ID_W'(N_PORTS - 1);
            rr_ptr     <= ID_W'(N_PORTS - 1);
            underrun_q <= 1'b0;
            count_q    <= '0;
        end else begin
            data_q     <= data_nx;
            control_q  <= control_nx;
            grant_q    <= grant_nx;
            gid_q      <= gid_nx;
            rr_ptr     <= rr_nx;
            underrun_q <= underrun_nx;
            count_q    <= count_nx;
        end
    end

    assign bus.req_ready   = (state == XFER) ? grant_q : '0;
    assign bus.data        = data_q;
    assign bus.control     = control_q;
    assign bus.grant       = grant_q;
    assign bus.grant_id    = gid_q;
    assign bus.busy        = (state != IDLE);
    assign bus.underrun    = underrun_q;
    assign bus.frame_count = count_q;

endmodule
